// File: rtl/cfg_pkg.sv
// Shared types and widths for the configuration scan loader.
package cfg_pkg;

  localparam int CFG_BYTE_W = 8;
  localparam int MISMATCH_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cfg_scan_loader_if.sv
// Host byte handshake between the configuration source and the scan loader.
interface cfg_scan_loader_if;
  import cfg_pkg::*;

  logic [CFG_BYTE_W-1:0] cfg_data;
  logic                  cfg_valid;
  logic                  cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);

endinterface

// File: rtl/cfg_scan_loader.sv
// Serialises host configuration bytes LSB-first into the fabric connection
// scan chain. A verify pass re-sends the same stream and compares the bit
// falling out of the chain tail against the bit being inserted.
module cfg_scan_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  scan_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  verify,
  cfg_scan_loader_if.slave      cfg_bus,
  output logic                  conn_scan_en,
  output logic                  conn_scan_in,
  input  logic                  conn_scan_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [MISMATCH_W-1:0] mismatch_cnt
);

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [CNT_W-1:0]        bits_left_q, bits_left_d;
  logic [3:0]              byte_bits_q, byte_bits_d;
  logic [CFG_BYTE_W-1:0]   shreg_q, shreg_d;
  logic [MISMATCH_W-1:0]   mism_q, mism_d;
  logic                    err_q, err_d;

  function automatic logic [MISMATCH_W-1:0] sat_inc(input logic [MISMATCH_W-1:0] v);
    return (v == {MISMATCH_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Last byte of the stream may be partial: clip the per-byte count to what
  // remains of the chain so the unused high bits never reach the chain.
  function automatic logic [3:0] clip_byte_bits(input logic [CNT_W-1:0] left);
    if (32'(left) < CFG_BYTE_W) return 4'(left);
    return 4'(CFG_BYTE_W);
  endfunction

  // Outputs decode directly from registers; nothing combinational from cfg_valid.
  assign cfg_bus.cfg_ready = (state_q == FETCH);
  assign conn_scan_en      = (state_q == SHIFT);
  assign conn_scan_in      = shreg_q[0];
  assign busy              = (state_q == FETCH) || (state_q == SHIFT);
  assign done              = (state_q == DONE);
  assign err               = err_q;
  assign mismatch_cnt      = mism_q;

  // Next-state and datapath update for the load/verify sequencer.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    bits_left_d = bits_left_q;
    byte_bits_d = byte_bits_q;
    shreg_d     = shreg_q;
    mism_d      = mism_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d      = verify;
          bits_left_d = CNT_W'(CHAIN_LEN);
          if (verify) begin
            mism_d = '0;
            err_d  = 1'b0;
          end
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (cfg_bus.cfg_valid) begin
          shreg_d     = cfg_bus.cfg_data;
          byte_bits_d = clip_byte_bits(bits_left_q);
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        shreg_d     = {1'b0, shreg_q[CFG_BYTE_W-1:1]};
        bits_left_d = bits_left_q - 1'b1;
        byte_bits_d = byte_bits_q - 1'b1;
        // Tail bit before this shift was inserted at the same position last pass.
        if (mode_q && (conn_scan_out != shreg_q[0])) begin
          mism_d = sat_inc(mism_q);
        end
        if (bits_left_q == CNT_W'(1)) begin
          state_d = DONE;
        end else if (byte_bits_q == 4'd1) begin
          state_d = FETCH;
        end
      end

      DONE: begin
        if (mode_q) begin
          err_d = (mism_q != '0);
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any pass in progress.
  always_ff @(posedge scan_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      bits_left_q <= '0;
      byte_bits_q <= '0;
      shreg_q     <= '0;
      mism_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      bits_left_q <= bits_left_d;
      byte_bits_q <= byte_bits_d;
      shreg_q     <= shreg_d;
      mism_q      <= mism_d;
      err_q       <= err_d;
    end
  end

endmodule
